// File: rtl/alu_exec_stage.sv
// Execute stage: runs the ALU op from the ALUControl code, resolves BEQ and holds the result in the EX/MEM register.
// Latency: 1 cycle from accept to out_valid; a new op can be accepted every cycle while out_ready is high.
// Backpressure: in_ready drops while the held result is stalled (out_valid && !out_ready); flush overrides everything.
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic             branch,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm_ext,
  input  logic [4:0]       rd,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_result,
  output logic             zero,
  output logic             pc_src,
  output logic [XLEN-1:0]  pc_target,
  output logic [4:0]       rd_out,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_out_valid;
  logic [XLEN-1:0]  r_alu_result;
  logic             r_zero;
  logic             r_pc_src;
  logic [XLEN-1:0]  r_pc_target;
  logic [4:0]       r_rd_out;
  logic             r_illegal_op;
  logic [CNT_W-1:0] r_retired_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [XLEN-1:0]  w_result;
  logic             w_illegal;
  logic             w_zero;
  logic             w_taken;

  // Ready whenever the EX/MEM slot is empty or being drained this cycle.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready && !flush;

  // ALU datapath; illegal codes produce a zero result and raise the illegal flag.
  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    unique case (alu_control)
      OP_ADD:  w_result = src_a + src_b;
      OP_SUB:  w_result = src_a - src_b;
      OP_AND:  w_result = src_a & src_b;
      OP_OR:   w_result = src_a | src_b;
      OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_zero  = (w_result == '0);
  assign w_taken = branch && w_zero;

  // EX/MEM register: flush clears the control flags, accept captures, drain clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_alu_result <= '0;
      r_zero       <= 1'b0;
      r_pc_src     <= 1'b0;
      r_pc_target  <= '0;
      r_rd_out     <= '0;
      r_illegal_op <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_pc_src     <= 1'b0;
      r_illegal_op <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_alu_result <= w_result;
      r_zero       <= w_zero;
      r_pc_src     <= w_taken;
      r_pc_target  <= pc + imm_ext;
      r_rd_out     <= rd;
      r_illegal_op <= w_illegal;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Saturating debug counters: accepted ops and taken branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired_cnt <= '0;
      r_taken_cnt   <= '0;
    end else if (w_accept) begin
      if (r_retired_cnt != CNT_MAX) begin
        r_retired_cnt <= r_retired_cnt + 1'b1;
      end
      if (w_taken && (r_taken_cnt != CNT_MAX)) begin
        r_taken_cnt <= r_taken_cnt + 1'b1;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign alu_result  = r_alu_result;
  assign zero        = r_zero;
  assign pc_src      = r_pc_src;
  assign pc_target   = r_pc_target;
  assign rd_out      = r_rd_out;
  assign illegal_op  = r_illegal_op;
  assign retired_cnt = r_retired_cnt;
  assign taken_cnt   = r_taken_cnt;

endmodule
